// File: rtl/bank_access_seq_pkg.sv
// Shared types and constants for the register-bank access sequencer.
package bank_access_seq_pkg;

    // Default operand and register-index widths
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Register 0 reads as zero and is never tracked or written
    localparam int unsigned ZERO_REG = 0;

    // Sequencer FSM: accept, read/stall, hand off downstream
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StHold = 2'd2
    } seq_state_e;

endpackage

// File: rtl/bank_access_seq_if.sv
// Bundle of the request, operand, write-back and bank-port signals of the sequencer.
interface bank_access_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);

    // Decode-side request
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic [ADDR_W-1:0] req_rd;
    logic              req_we;

    // Execute-side operands
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_rd;
    logic              op_we;

    // Write-back stream (always accepted)
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dir;
    logic [DATA_W-1:0] wb_data;

    // Register bank port group
    logic              Rw;
    logic [ADDR_W-1:0] Rd1;
    logic [ADDR_W-1:0] Rd2;
    logic [ADDR_W-1:0] Dir;
    logic [DATA_W-1:0] DIn;
    logic [DATA_W-1:0] L1;
    logic [DATA_W-1:0] L2;

    // Sequencer side
    modport master (
        input  req_valid, req_rs, req_rt, req_rd, req_we,
        output req_ready,
        output op_valid, op_a, op_b, op_rd, op_we,
        input  op_ready,
        input  wb_valid, wb_dir, wb_data,
        output Rw, Rd1, Rd2, Dir, DIn,
        input  L1, L2
    );

    // Environment side: decode, execute, write-back source and the bank itself
    modport slave (
        output req_valid, req_rs, req_rt, req_rd, req_we,
        input  req_ready,
        input  op_valid, op_a, op_b, op_rd, op_we,
        output op_ready,
        output wb_valid, wb_dir, wb_data,
        input  Rw, Rd1, Rd2, Dir, DIn,
        output L1, L2
    );

endinterface

// File: rtl/bank_access_seq_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
module bank_access_seq_scoreboard #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] rd_idx_a_i,
    input  logic [ADDR_W-1:0] rd_idx_b_i,
    input  logic [ADDR_W-1:0] rd_idx_c_i,
    output logic              pend_a_o,
    output logic              pend_b_o,
    output logic              pend_c_o
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [NumRegs-1:0] pending_q, pending_d;
    logic [NumRegs-1:0] set_mask, clr_mask;

    // Next pending vector: clear first, then set so a coincident set wins
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_idx_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    // Pending vector register, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pend_a_o = pending_q[rd_idx_a_i];
    assign pend_b_o = pending_q[rd_idx_b_i];
    assign pend_c_o = pending_q[rd_idx_c_i];

endmodule

// File: rtl/bank_access_seq.sv
// Operand-fetch / write-back sequencer in front of the register bank.
module bank_access_seq
    import bank_access_seq_pkg::*;
#(
    parameter int unsigned DATA_W = bank_access_seq_pkg::DATA_W,
    parameter int unsigned ADDR_W = bank_access_seq_pkg::ADDR_W
) (
    input logic               clk,
    input logic               rst,
    bank_access_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(ZERO_REG);

    seq_state_e state_q, state_d;

    logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic              we_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [DATA_W-1:0] op_a_sel, op_b_sel;

    logic pend_rs, pend_rt, pend_rd;
    logic bypass_rs, bypass_rt;
    logic blocked;
    logic accept, capture, set_en;

    // Bypass: a write-back landing this cycle supplies the operand directly
    assign bypass_rs = bus.wb_valid && (bus.wb_dir == rs_q) && (rs_q != RegZero);
    assign bypass_rt = bus.wb_valid && (bus.wb_dir == rt_q) && (rt_q != RegZero);

    // WAW hazards are not bypassed: wait until the older write has retired
    assign blocked = (pend_rs && !bypass_rs) || (pend_rt && !bypass_rt) ||
                     (we_q && (rd_q != RegZero) && pend_rd);

    assign accept = bus.req_valid && bus.req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid) state_d = StRead;
            StRead:  if (!blocked)      state_d = StHold;
            StHold:  if (bus.op_ready)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and control strobes
    always_comb begin
        bus.req_ready = 1'b0;
        bus.op_valid  = 1'b0;
        capture       = 1'b0;
        set_en        = 1'b0;
        unique case (state_q)
            StIdle:  bus.req_ready = !rst;
            StRead:  capture = !blocked;
            StHold: begin
                bus.op_valid = 1'b1;
                set_en       = bus.op_ready && we_q && (rd_q != RegZero);
            end
            default: ;
        endcase
    end

    // Request latch; also feeds the bank read indices between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q <= '0;
            rt_q <= '0;
            rd_q <= '0;
            we_q <= 1'b0;
        end else if (accept) begin
            rs_q <= bus.req_rs;
            rt_q <= bus.req_rt;
            rd_q <= bus.req_rd;
            we_q <= bus.req_we;
        end
    end

    // Operand source select: zero register, bypass, or bank read
    always_comb begin
        if (rs_q == RegZero) op_a_sel = '0;
        else if (bypass_rs)  op_a_sel = bus.wb_data;
        else                 op_a_sel = bus.L1;
        if (rt_q == RegZero) op_b_sel = '0;
        else if (bypass_rt)  op_b_sel = bus.wb_data;
        else                 op_b_sel = bus.L2;
    end

    // Operand registers, loaded only on the READ->HOLD transition
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (capture) begin
            op_a_q <= op_a_sel;
            op_b_q <= op_b_sel;
        end
    end

    bank_access_seq_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk),
        .rst_i      (rst),
        .set_en_i   (set_en),
        .set_idx_i  (rd_q),
        .clr_en_i   (bus.wb_valid),
        .clr_idx_i  (bus.wb_dir),
        .rd_idx_a_i (rs_q),
        .rd_idx_b_i (rt_q),
        .rd_idx_c_i (rd_q),
        .pend_a_o   (pend_rs),
        .pend_b_o   (pend_rt),
        .pend_c_o   (pend_rd)
    );

    assign bus.op_a = op_a_q;
    assign bus.op_b = op_b_q;
    assign bus.op_rd = rd_q;
    assign bus.op_we = we_q;

    assign bus.Rd1 = rs_q;
    assign bus.Rd2 = rt_q;

    // Write-back passes straight through to the bank; register 0 is never written
    assign bus.Rw  = bus.wb_valid && (bus.wb_dir != RegZero);
    assign bus.Dir = bus.wb_dir;
    assign bus.DIn = bus.wb_data;

endmodule

// File: tb/tb_bank_access_seq.sv
// Randomised bench for bank_access_seq against a cycle-level behavioural model.
module tb_bank_access_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bank_access_seq_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    bank_access_seq #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register bank: combinational read, written from the DUT's bank write port
    logic [31:0] bank_mem [32];

    always_comb begin
        bus.L1 = bank_mem[bus.Rd1];
        bus.L2 = bank_mem[bus.Rd2];
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural registers, outstanding writes, request in flight
    logic [31:0] ref_regs [32];
    bit   [31:0] m_pending;
    int          m_state;   // 0 waiting for request, 1 reading, 2 offering operands
    int          m_rs, m_rt, m_rd;
    bit          m_we;
    logic [31:0] m_op_a, m_op_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register value once this cycle's write-back has landed
    function automatic logic [31:0] reg_after(input int idx, input bit wbv, input int wd,
                                              input logic [31:0] wdata);
        if (idx == 0) return 32'h0;
        if (wbv && wd == idx) return wdata;
        return ref_regs[idx];
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the model and the bank
    task automatic cyc(input bit r, input bit rv, input int rs, input int rt, input int rd,
                       input bit we, input bit ordy, input bit wbv, input int wd,
                       input logic [31:0] wdata);
        bit          blocked;
        bit   [31:0] new_pend;
        logic        wr_en;
        logic [4:0]  wr_dir;
        logic [31:0] wr_dat;
        @(negedge clk);
        rst           = r;
        bus.req_valid = rv;
        bus.req_rs    = 5'(rs);
        bus.req_rt    = 5'(rt);
        bus.req_rd    = 5'(rd);
        bus.req_we    = we;
        bus.op_ready  = ordy;
        bus.wb_valid  = wbv;
        bus.wb_dir    = 5'(wd);
        bus.wb_data   = wdata;
        #1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(!r && m_state == 0));
        check_eq("op_valid", 32'(bus.op_valid), 32'(m_state == 2));
        if (m_state == 2) begin
            check_eq("op_a", bus.op_a, m_op_a);
            check_eq("op_b", bus.op_b, m_op_b);
            check_eq("op_rd", 32'(bus.op_rd), 32'(m_rd));
            check_eq("op_we", 32'(bus.op_we), 32'(m_we));
        end
        check_eq("Rw", 32'(bus.Rw), 32'(wbv && wd != 0));
        if (wbv) begin
            check_eq("Dir", 32'(bus.Dir), 32'(wd));
            check_eq("DIn", bus.DIn, wdata);
        end
        check_eq("Rd1", 32'(bus.Rd1), 32'(m_rs));
        check_eq("Rd2", 32'(bus.Rd2), 32'(m_rt));
        wr_en  = bus.Rw;
        wr_dir = bus.Dir;
        wr_dat = bus.DIn;

        new_pend = m_pending;
        if (wbv) new_pend[wd] = 1'b0;
        if (r) begin
            m_state   = 0;
            m_pending = '0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_we = 1'b0;
            m_op_a = '0; m_op_b = '0;
        end else begin
            case (m_state)
                0: if (rv) begin
                    m_rs = rs; m_rt = rt; m_rd = rd; m_we = we;
                    m_state = 1;
                end
                1: begin
                    // A source may be read only once its outstanding write is landing
                    blocked = (m_pending[m_rs] && !(wbv && wd == m_rs)) ||
                              (m_pending[m_rt] && !(wbv && wd == m_rt)) ||
                              (m_we && m_rd != 0 && m_pending[m_rd]);
                    if (!blocked) begin
                        m_op_a  = reg_after(m_rs, wbv, wd, wdata);
                        m_op_b  = reg_after(m_rt, wbv, wd, wdata);
                        m_state = 2;
                    end
                end
                default: if (ordy) begin
                    if (m_we && m_rd != 0) new_pend[m_rd] = 1'b1;
                    m_state = 0;
                end
            endcase
            m_pending = new_pend;
        end
        if (wbv && wd != 0) ref_regs[wd] = wdata;

        @(posedge clk);
        #1;
        if (wr_en) bank_mem[wr_dir] = wr_dat;
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, ordy, 1'b0, 0, 32'h0);
    endtask

    task automatic req(input int rs, input int rt, input int rd, input bit we);
        cyc(1'b0, 1'b1, rs, rt, rd, we, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic wb(input int wd, input logic [31:0] wdata, input bit ordy);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, ordy, 1'b1, wd, wdata);
    endtask

    initial begin
        bit   r, rv, we, ordy, wbv;
        int   rs, rt, rd, wd;
        logic [31:0] wdata;

        for (int i = 0; i < 32; i++) begin
            bank_mem[i] = $urandom;
            ref_regs[i] = bank_mem[i];
        end
        bank_mem[0] = 32'hFFFF_FFFF;
        ref_regs[0] = 32'h0;
        bank_mem[3] = 32'h11; ref_regs[3] = 32'h11;
        bank_mem[4] = 32'h22; ref_regs[4] = 32'h22;
        m_pending = '0;
        m_state = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_we = 1'b0;
        m_op_a = '0; m_op_b = '0;

        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0;
        bus.req_we = 1'b0; bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_dir = '0; bus.wb_data = '0;

        // Reset, with a request held at the input that must not be accepted
        cyc(1'b1, 1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        cyc(1'b1, 1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        idle(1'b0);
        check_eq("rst_op_valid", 32'(bus.op_valid), 32'h0);
        check_eq("rst_op_a", bus.op_a, 32'h0);
        check_eq("rst_op_b", bus.op_b, 32'h0);
        check_eq("rst_op_rd", 32'(bus.op_rd), 32'h0);
        check_eq("rst_op_we", 32'(bus.op_we), 32'h0);

        // Unblocked request: operands one cycle after accept
        req(3, 4, 5, 1'b1);
        idle(1'b0);
        check_eq("lat_op_valid", 32'(bus.op_valid), 32'h1);
        check_eq("lat_op_a", bus.op_a, 32'h11);
        check_eq("lat_op_b", bus.op_b, 32'h22);
        idle(1'b1);

        // RAW stall on r5, released by a bypassed write-back in stall cycle 3
        req(5, 4, 6, 1'b0);
        idle(1'b0);
        check_eq("raw_stall_valid", 32'(bus.op_valid), 32'h0);
        check_eq("raw_stall_ready", 32'(bus.req_ready), 32'h0);
        idle(1'b0);
        wb(5, 32'hABCD, 1'b0);
        check_eq("byp_Rw", 32'(bus.Rw), 32'h1);
        check_eq("byp_Dir", 32'(bus.Dir), 32'h5);
        check_eq("byp_op_valid", 32'(bus.op_valid), 32'h1);
        check_eq("byp_op_a", bus.op_a, 32'hABCD);
        idle(1'b1);

        // Register 0 reads as zero; write-back to 0 does not reach the bank
        req(0, 0, 0, 1'b0);
        wb(0, 32'h1234, 1'b0);
        check_eq("r0_Rw", 32'(bus.Rw), 32'h0);
        check_eq("r0_op_a", bus.op_a, 32'h0);
        check_eq("r0_op_b", bus.op_b, 32'h0);
        idle(1'b1);

        // WAW on r7; coincident set and clear in the handshake cycle leaves r7 pending
        req(1, 2, 7, 1'b1);
        idle(1'b0);
        idle(1'b1);
        req(1, 2, 7, 1'b1);
        idle(1'b0);
        check_eq("waw_stall", 32'(bus.op_valid), 32'h0);
        wb(7, 32'h7777, 1'b0);
        check_eq("waw_same_cycle", 32'(bus.op_valid), 32'h0);
        idle(1'b0);
        check_eq("waw_release", 32'(bus.op_valid), 32'h1);
        wb(7, 32'h7070, 1'b1);
        req(7, 0, 0, 1'b0);
        idle(1'b0);
        check_eq("set_wins_stall", 32'(bus.op_valid), 32'h0);
        wb(7, 32'h0777, 1'b0);
        check_eq("set_wins_byp", bus.op_a, 32'h0777);
        idle(1'b1);

        // Leave r9 pending, then reset while operands are being held
        req(1, 2, 9, 1'b1);
        idle(1'b0);
        idle(1'b1);
        req(1, 2, 8, 1'b1);
        idle(1'b0);
        idle(1'b0);
        check_eq("hold_ready", 32'(bus.req_ready), 32'h0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        check_eq("mid_rst_valid", 32'(bus.op_valid), 32'h0);
        idle(1'b0);
        idle(1'b0);
        req(9, 9, 0, 1'b0);
        idle(1'b0);
        check_eq("rst_clears_pend", 32'(bus.op_valid), 32'h1);
        idle(1'b1);

        // Random traffic with hazards concentrated on a few registers
        for (int n = 0; n < 3000; n++) begin
            r     = ($urandom_range(0, 249) == 0);
            rv    = $urandom_range(0, 1) == 1;
            rs    = $urandom_range(0, 7);
            rt    = $urandom_range(0, 7);
            rd    = $urandom_range(0, 7);
            we    = $urandom_range(0, 3) != 0;
            ordy  = $urandom_range(0, 2) != 0;
            wbv   = $urandom_range(0, 2) == 0;
            wdata = $urandom;
            if (m_pending != 0 && $urandom_range(0, 1) == 1) begin
                wd = $urandom_range(0, 31);
                while (!m_pending[wd]) wd = $urandom_range(0, 31);
            end else begin
                wd = $urandom_range(0, 7);
            end
            cyc(r, rv, rs, rt, rd, we, ordy, wbv, wd, wdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
